hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline interlock controller for the 24-bit five-stage core (fetch, decode, execute, memory, writeback). Has no forwarding paths. Watches the instruction sitting in decode and tracks in-flight register and flag writes in a 3-entry scoreboard. It holds fetch/decode on read-after-write hazards, kills wrong-path instructions on a taken branch, and freezes the whole pipeline while data memory is busy. It also keeps saturating stall and flush counters for debug.

## Interface
- `SB_DEPTH`, default 3: scoreboard entries covering EX, MEM, WB. The WB entry still counts as a hazard; the register file has no write-through.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: asynchronous, active-low; clears all state.
- `instr_d` in, 24: instruction in the decode stage.
- `instr_valid_d` in, 1: `instr_d` is a real instruction, not a bubble.
- `branch_taken_e` in, 1: taken branch resolved in execute (the pcWe of the EX instruction).
- `mem_busy` in, 1: data memory not ready.
- `stall_f` out, 1: hold the PC.
- `stall_d` out, 1: hold the F/D register.
- `flush_d` out, 1: load a bubble into the F/D register.
- `bubble_e` out, 1: load a bubble (all write enables 0) into the D/E register.
- `freeze` out, 1: every pipeline register holds.
- `stall_cnt` out, `CNT_W`: RAW-stall cycles, saturating.
- `flush_cnt` out, `CNT_W`: taken-branch flushes, saturating.

## Operation
Instruction classes, decoded from `instr_d` (srcA = [15:12], srcB = [11:8], reg = [19:16]):
- **ALU**, `instr[23]=0`
  - writes reg.
  - reads srcA; reads srcB only when `instr[0]=1`.
- **CMP**, `instr[23:20]=1000`
  - writes flags only.
  - reads srcA, and srcB when `instr[0]=1`.
- **MEM**, `instr[23:22]=10`, `instr[21:20]≠00`
  - Load (`instr[1]=0`): writes reg, reads srcA.
  - Store (`instr[1]=1`): reads srcA and reg; writes nothing.
- **BR**, `instr[23:22]=11`
  - no GPR access.
  - reads flags when `instr[21:20]≠00`.

Scoreboard:
- Shift register of `SB_DEPTH` entries, each {valid, tag[3:0], flag}. Entry 0 is EX.
- RAW hazard is true when `instr_valid_d` is set and some valid entry either has a tag equal to a register the decode instruction reads, or has flag=1 while the decode instruction reads flags.
- R0 is not special; it is tracked like any other register.

Per-cycle priority, highest first:
1. `mem_busy` = 1
   - `freeze`=1, `stall_f`=1, `stall_d`=1.
   - `flush_d`=0, `bubble_e`=0.
   - Scoreboard and counters hold. A pending `branch_taken_e` waits until the freeze is released.
2. `branch_taken_e` = 1
   - `flush_d`=1, `bubble_e`=1, stalls 0.
   - Scoreboard shifts with an empty entry 0.
   - `flush_cnt` += 1. The RAW hazard is ignored (wrong path).
3. RAW hazard
   - `stall_f`=1, `stall_d`=1, `bubble_e`=1.
   - Scoreboard shifts with an empty entry 0.
   - `stall_cnt` += 1.
4. Otherwise
   - All outputs 0.
   - Scoreboard shifts in the decode instruction's {valid, dest, flag}. valid=0 for bubbles and for non-writers.

Counters saturate at all-ones and never wrap.

## Timing
- `stall_f`, `stall_d`, `flush_d`, `bubble_e`, `freeze` are combinational from the registered scoreboard plus the current inputs. They are valid in the same cycle and have no internal combinational loop.
- Scoreboard and counters update at the rising edge.
- Back-to-back dependent ALU ops: consumer stalls exactly 3 cycles, then issues on the 4th.
- A dependency two instructions apart costs 2 stall cycles; three apart costs 1.
- Reset (asserted at any time, including mid-stall):
  - scoreboard cleared immediately, counters 0.
  - outputs fall to 0 unless `mem_busy` or `branch_taken_e` is set.
- Simultaneous `mem_busy` and `branch_taken_e`: freeze wins and the flush is not counted.

## Structure
- Package `hazard_pkg`:
  - `instr_class_t` enum (ALU, CMP, MEM, BR).
  - `sb_entry_t` struct.
  - opcode field constants.
- Sub-module `instr_classifier` (combinational): `instr_d` → class, srcA/srcB/reg use bits, dest valid, dest tag, writes_flags, reads_flags.
- Top level holds the scoreboard, priority logic and counters.

## Test plan
- ALU writing R3, then ALU reading R3 as srcA → `stall_d`=1 for 3 cycles, issue on cycle 4; `stall_cnt`=3.
- ALU writing R5, then ALU with srcB=R5 and `instr[0]=0` (immediate) → no stall.
- CMP, then conditional BR → BR stalls 3 cycles; an unconditional BR after CMP → no stall.
- Consumer stalled on R2 while `branch_taken_e`=1 → `flush_d`=1, `bubble_e`=1, `stall_d`=0; `flush_cnt`=1, `stall_cnt` unchanged.
- `mem_busy` held 4 cycles during a RAW stall → `freeze`=1, stall countdown paused; the 3 stall cycles still elapse after release.
- Force `stall_cnt` to 0xFFFE, then 3 stall cycles → reads 0xFFFF. Pulse reset low mid-stall → all outputs and counters 0 in that cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and opcode field constants for the pipeline interlock controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_CMP = 2'd1,
        CLS_MEM = 2'd2,
        CLS_BR  = 2'd3
    } instr_class_t;

    // An entry records either a GPR write (flag=0, tag valid) or a flag write (flag=1).
    typedef struct packed {
        logic       valid;
        logic [3:0] tag;
        logic       flag;
    } sb_entry_t;

    localparam int unsigned OPC_ALU_BIT = 23;
    localparam logic [3:0]  OPC_CMP     = 4'b1000;
    localparam logic [1:0]  OPC_MEM     = 2'b10;
    localparam logic [1:0]  OPC_BR      = 2'b11;
    localparam logic [1:0]  SUB_NONE    = 2'b00;
    localparam int unsigned BIT_USE_B   = 0;
    localparam int unsigned BIT_STORE   = 1;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage / pipeline-control bundle between the core and the hazard unit.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [23:0]      instr_d;
    logic             instr_valid_d;
    logic             branch_taken_e;
    logic             mem_busy;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             bubble_e;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output instr_d, instr_valid_d, branch_taken_e, mem_busy,
        input  stall_f, stall_d, flush_d, bubble_e, freeze, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr_d, instr_valid_d, branch_taken_e, mem_busy,
        output stall_f, stall_d, flush_d, bubble_e, freeze, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit_instr_classifier.sv
// Combinational decode of the decode-stage instruction into read/write usage.
module instr_classifier
    import hazard_pkg::*;
(
    input  logic [23:0]  instr_i,
    output instr_class_t cls_o,
    output logic [3:0]   src_a_o,
    output logic [3:0]   src_b_o,
    output logic [3:0]   reg_o,
    output logic         use_a_o,
    output logic         use_b_o,
    output logic         use_reg_o,
    output logic         dest_valid_o,
    output logic         writes_flags_o,
    output logic         reads_flags_o
);
    logic unused_bits;
    assign unused_bits = ^instr_i[7:2];

    assign src_a_o = instr_i[15:12];
    assign src_b_o = instr_i[11:8];
    assign reg_o   = instr_i[19:16];

    always_comb begin
        if (instr_i[OPC_ALU_BIT] == 1'b0) begin
            cls_o = CLS_ALU;
        end else if (instr_i[23:22] == OPC_BR) begin
            cls_o = CLS_BR;
        end else if (instr_i[23:20] == OPC_CMP) begin
            cls_o = CLS_CMP;
        end else begin
            cls_o = CLS_MEM;
        end
    end

    always_comb begin
        use_a_o        = 1'b0;
        use_b_o        = 1'b0;
        use_reg_o      = 1'b0;
        dest_valid_o   = 1'b0;
        writes_flags_o = 1'b0;
        reads_flags_o  = 1'b0;
        unique case (cls_o)
            CLS_ALU: begin
                use_a_o      = 1'b1;
                use_b_o      = instr_i[BIT_USE_B];
                dest_valid_o = 1'b1;
            end
            CLS_CMP: begin
                use_a_o        = 1'b1;
                use_b_o        = instr_i[BIT_USE_B];
                writes_flags_o = 1'b1;
            end
            CLS_MEM: begin
                use_a_o      = 1'b1;
                use_reg_o    = instr_i[BIT_STORE];
                dest_valid_o = ~instr_i[BIT_STORE];
            end
            CLS_BR: begin
                reads_flags_o = (instr_i[21:20] != SUB_NONE);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/hazard_unit.sv
// Interlock controller: scoreboard of in-flight writes, stall/flush/freeze priority, debug counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  bus
);
    instr_class_t cls;
    logic [3:0]   src_a, src_b, reg_f;
    logic         use_a, use_b, use_reg, dest_valid, writes_flags, reads_flags;

    instr_classifier u_classifier (
        .instr_i        (bus.instr_d),
        .cls_o          (cls),
        .src_a_o        (src_a),
        .src_b_o        (src_b),
        .reg_o          (reg_f),
        .use_a_o        (use_a),
        .use_b_o        (use_b),
        .use_reg_o      (use_reg),
        .dest_valid_o   (dest_valid),
        .writes_flags_o (writes_flags),
        .reads_flags_o  (reads_flags)
    );

    sb_entry_t [SB_DEPTH-1:0] sb_q;
    logic [CNT_W-1:0]         stall_cnt_q, flush_cnt_q;
    logic                     raw;
    sb_entry_t                issue_entry;

    // Flag entries never match on tag: no instruction writes both a GPR and the flags.
    always_comb begin
        raw = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb_q[i].valid) begin
                if (sb_q[i].flag) begin
                    raw = raw | reads_flags;
                end else begin
                    raw = raw | (use_a   && (sb_q[i].tag == src_a))
                              | (use_b   && (sb_q[i].tag == src_b))
                              | (use_reg && (sb_q[i].tag == reg_f));
                end
            end
        end
        raw = raw & bus.instr_valid_d;
    end

    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = bus.instr_valid_d && (cls != CLS_BR) && (dest_valid || writes_flags);
        issue_entry.tag   = reg_f;
        issue_entry.flag  = writes_flags;
    end

    assign bus.freeze    = bus.mem_busy;
    assign bus.stall_f   = bus.mem_busy | (~bus.branch_taken_e & raw);
    assign bus.stall_d   = bus.mem_busy | (~bus.branch_taken_e & raw);
    assign bus.flush_d   = ~bus.mem_busy & bus.branch_taken_e;
    assign bus.bubble_e  = ~bus.mem_busy & (bus.branch_taken_e | raw);
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.mem_busy) begin
            if (bus.branch_taken_e) begin
                sb_q <= {sb_q[SB_DEPTH-2:0], sb_entry_t'('0)};
                if (!(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else if (raw) begin
                sb_q <= {sb_q[SB_DEPTH-2:0], sb_entry_t'('0)};
                if (!(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                sb_q <= {sb_q[SB_DEPTH-2:0], issue_entry};
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed checks of hazard_unit against a per-register busy-countdown model.
module tb_hazard_unit;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CW))  bus ();
    hazard_unit_if #(.CNT_W(CWS)) bus_s ();

    hazard_unit #(.SB_DEPTH(3), .CNT_W(CW))  dut     (.clk(clk), .reset(rst_n), .bus(bus));
    hazard_unit #(.SB_DEPTH(3), .CNT_W(CWS)) dut_sat (.clk(clk), .reset(rst_n), .bus(bus_s));

    int n_chk = 0;
    int n_bad = 0;

    // Model: cycles until each register / the flags are safe to read.
    int busy_reg[16];
    int busy_flag;
    int m_stall, m_flush, m_stall_s, m_flush_s;

    logic [23:0] cur_ins;
    logic        cur_v, cur_br, cur_mb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk_alu(input int d, input int a, input int b, input bit useb);
        logic [23:0] x;
        x = 24'h0;
        x[19:16] = 4'(d); x[15:12] = 4'(a); x[11:8] = 4'(b); x[0] = useb;
        return x;
    endfunction

    function automatic logic [23:0] mk_cmp(input int a);
        logic [23:0] x;
        x = 24'h800000;
        x[15:12] = 4'(a);
        return x;
    endfunction

    function automatic bit model_raw();
        bit ra, rb, rr, rf;
        ra = 0; rb = 0; rr = 0; rf = 0;
        if (!cur_ins[23] || cur_ins[23:20] == 4'b1000) begin
            ra = 1; rb = cur_ins[0];
        end else if (cur_ins[23:22] == 2'b10) begin
            ra = 1; rr = cur_ins[1];
        end else begin
            rf = (cur_ins[21:20] != 2'b00);
        end
        return cur_v && ((ra && busy_reg[cur_ins[15:12]] > 0) ||
                         (rb && busy_reg[cur_ins[11:8]]  > 0) ||
                         (rr && busy_reg[cur_ins[19:16]] > 0) ||
                         (rf && busy_flag > 0));
    endfunction

    function automatic logic [4:0] model_ctl();
        if (cur_mb)      return 5'b11001;
        if (cur_br)      return 5'b00110;
        if (model_raw()) return 5'b11010;
        return 5'b00000;
    endfunction

    task automatic model_edge();
        bit raw;
        raw = model_raw();
        if (cur_mb) return;
        for (int r = 0; r < 16; r++) if (busy_reg[r] > 0) busy_reg[r]--;
        if (busy_flag > 0) busy_flag--;
        if (cur_br) begin
            if (m_flush < (1 << CW) - 1)    m_flush++;
            if (m_flush_s < (1 << CWS) - 1) m_flush_s++;
        end else if (raw) begin
            if (m_stall < (1 << CW) - 1)    m_stall++;
            if (m_stall_s < (1 << CWS) - 1) m_stall_s++;
        end else if (cur_v) begin
            if (!cur_ins[23] || (cur_ins[23:22] == 2'b10 && cur_ins[21:20] != 2'b00 && !cur_ins[1]))
                busy_reg[cur_ins[19:16]] = 3;
            if (cur_ins[23:20] == 4'b1000) busy_flag = 3;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) busy_reg[r] = 0;
        busy_flag = 0;
        m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    task automatic drive(input logic [23:0] ins, input logic v, input logic br, input logic mb);
        cur_ins = ins; cur_v = v; cur_br = br; cur_mb = mb;
        bus.instr_d = ins;   bus.instr_valid_d = v;   bus.branch_taken_e = br;   bus.mem_busy = mb;
        bus_s.instr_d = ins; bus_s.instr_valid_d = v; bus_s.branch_taken_e = br; bus_s.mem_busy = mb;
    endtask

    function automatic logic [4:0] dut_ctl();
        return {bus.stall_f, bus.stall_d, bus.flush_d, bus.bubble_e, bus.freeze};
    endfunction

    task automatic step(input logic [23:0] ins, input logic v, input logic br, input logic mb);
        drive(ins, v, br, mb);
        #1;
        check_eq("ctl", 32'(dut_ctl()), 32'(model_ctl()));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        check_eq("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        check_eq("stall_cnt_sat", 32'(bus_s.stall_cnt), 32'(m_stall_s));
        check_eq("flush_cnt_sat", 32'(bus_s.flush_cnt), 32'(m_flush_s));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(24'h0, 1'b0, 1'b0, 1'b0);
        #2;
        model_reset();
        check_eq("rst_ctl", 32'(dut_ctl()), 32'h0);
        check_eq("rst_stall", 32'(bus.stall_cnt), 32'h0);
        check_eq("rst_flush", 32'(bus.flush_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [23:0] ins;
        model_reset();
        do_reset();

        // Back-to-back RAW on R3: three stalls, issue on the fourth.
        step(mk_alu(3, 1, 1, 0), 1, 0, 0);
        repeat (4) step(mk_alu(4, 3, 0, 0), 1, 0, 0);
        check_eq("tp_raw3", 32'(bus.stall_cnt), 32'd3);

        // Immediate form does not read srcB.
        do_reset();
        step(mk_alu(5, 1, 1, 0), 1, 0, 0);
        step(mk_alu(6, 0, 5, 0), 1, 0, 0);
        check_eq("tp_imm", 32'(bus.stall_cnt), 32'd0);

        // Dependency distance 2 and 3.
        do_reset();
        step(mk_alu(7, 0, 0, 0), 1, 0, 0);
        step(mk_alu(8, 0, 0, 0), 1, 0, 0);
        repeat (3) step(mk_alu(9, 7, 0, 0), 1, 0, 0);
        check_eq("tp_dist2", 32'(bus.stall_cnt), 32'd2);

        // CMP then conditional branch stalls; unconditional does not.
        do_reset();
        step(mk_cmp(1), 1, 0, 0);
        repeat (4) step(24'hD00000, 1, 0, 0);
        check_eq("tp_brc", 32'(bus.stall_cnt), 32'd3);
        do_reset();
        step(mk_cmp(1), 1, 0, 0);
        step(24'hC00000, 1, 0, 0);
        check_eq("tp_bru", 32'(bus.stall_cnt), 32'd0);

        // Taken branch overrides a RAW stall.
        do_reset();
        step(mk_alu(2, 0, 0, 0), 1, 0, 0);
        step(mk_alu(3, 2, 0, 0), 1, 0, 0);
        step(mk_alu(3, 2, 0, 0), 1, 1, 0);
        check_eq("tp_br_flush", 32'(bus.flush_cnt), 32'd1);
        check_eq("tp_br_stall", 32'(bus.stall_cnt), 32'd1);

        // Freeze for 4 cycles mid-stall; countdown resumes after release.
        do_reset();
        step(mk_alu(2, 0, 0, 0), 1, 0, 0);
        step(mk_alu(3, 2, 0, 0), 1, 0, 0);
        repeat (4) step(mk_alu(3, 2, 0, 0), 1, 1, 1);
        repeat (3) step(mk_alu(3, 2, 0, 0), 1, 0, 0);
        check_eq("tp_freeze_stall", 32'(bus.stall_cnt), 32'd3);
        check_eq("tp_freeze_flush", 32'(bus.flush_cnt), 32'd0);

        // Asynchronous reset while a stall is in progress.
        do_reset();
        step(mk_alu(3, 0, 0, 0), 1, 0, 0);
        step(mk_alu(4, 3, 0, 0), 1, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("tp_rst_ctl", 32'(dut_ctl()), 32'h0);
        check_eq("tp_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        rst_n = 1'b1;
        #1;
        step(mk_alu(4, 3, 0, 0), 1, 0, 0);

        // Saturation on the narrow-counter instance.
        do_reset();
        repeat (6) begin
            step(mk_alu(1, 0, 0, 0), 1, 0, 0);
            repeat (4) step(mk_alu(2, 1, 0, 0), 1, 0, 0);
        end
        check_eq("tp_sat", 32'(bus_s.stall_cnt), 32'd15);
        check_eq("tp_nosat", 32'(bus.stall_cnt), 32'd18);

        // Random traffic over a small register set to provoke hazards.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ins = 24'($urandom);
            ins[19:16] = 4'($urandom_range(0, 3));
            ins[15:12] = 4'($urandom_range(0, 3));
            ins[11:8]  = 4'($urandom_range(0, 3));
            step(ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 15));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
